dp_ram_b_arbiter: RTL and testbench

//  Shares the single data port (port B) of the testbench dual-port RAM among NUM_REQ
//  OBI-style masters: core LSU, debug/loader, DMA. Grants one access per cycle, round-robin.

---
 rtl/dp_ram_arb_pkg.sv | 26 ++
 rtl/dp_ram_b_arbiter_rr.sv | 46 ++++
 rtl/dp_ram_b_arbiter.sv | 99 +++++++++
 tb/tb_dp_ram_b_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_arb_pkg.sv
// rtl/dp_ram_arb_pkg.sv - shared types and helpers for the port-B arbiter
package dp_ram_arb_pkg;

  localparam int unsigned MAX_NUM_REQ = 8;

  typedef logic [$clog2(MAX_NUM_REQ)-1:0] idx_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

  // Next round-robin start position after serving index i out of n masters.
  function automatic idx_t wrap_inc(input idx_t i, input int unsigned n);
    if (32'(i) + 32'd1 >= n) return '0;
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/dp_ram_b_arbiter_rr.sv
// rtl/dp_ram_b_arbiter_rr.sv - round-robin arbiter, one-hot grant plus index
module rr_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output idx_t         idx_o
);

  idx_t       ptr_q, ptr_d;
  idx_t       idx_d;
  logic       found;
  logic [3:0] cand;
  logic [N-1:0] req_sh;

  // Scan from the pointer upward, wrapping, and take the first requester.
  always_comb begin
    idx_d  = '0;
    found  = 1'b0;
    cand   = '0;
    req_sh = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 4'(ptr_q) + 4'(i);
      if (cand >= 4'(N)) cand = cand - 4'(N);
      req_sh = req_i >> cand;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        idx_d = idx_t'(cand);
      end
    end
  end

  assign gnt_o = found ? (N'(1) << idx_d) : '0;
  assign idx_o = idx_d;
  assign ptr_d = found ? wrap_inc(idx_d, N) : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dp_ram_b_arbiter.sv
// rtl/dp_ram_b_arbiter.sv - shares RAM port B among NUM_REQ masters with range check
module dp_ram_b_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 22,
  parameter logic [32:0] MAX_ADDR   = 33'(1) << ADDR_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0][31:0]  addr_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ-1:0][3:0]   be_i,
  input  logic [NUM_REQ-1:0][31:0]  wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic                      ram_en_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic                      ram_we_o,
  output logic [3:0]                ram_be_o,
  output logic [31:0]               ram_wdata_o,
  input  logic [31:0]               ram_rdata_i
);

  logic [NUM_REQ-1:0] gnt;
  idx_t               gnt_idx;
  obi_req_t           sel_req;
  obi_rsp_t           rsp;
  logic               any_gnt;
  logic               legal;

  logic rsp_valid_q, rsp_valid_d;
  idx_t rsp_idx_q, rsp_idx_d;
  logic rsp_err_q, rsp_err_d;
  logic rsp_we_q, rsp_we_d;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  always_comb begin
    sel_req = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) sel_req = '{addr: addr_i[k], we: we_i[k], be: be_i[k], wdata: wdata_i[k]};
    end
  end

  assign any_gnt     = |gnt;
  assign legal       = {1'b0, sel_req.addr} < MAX_ADDR;
  assign gnt_o       = gnt;
  assign ram_en_o    = any_gnt & legal;
  assign ram_addr_o  = sel_req.addr[ADDR_WIDTH-1:0];
  assign ram_we_o    = sel_req.we;
  assign ram_be_o    = sel_req.be;
  assign ram_wdata_o = sel_req.wdata;

  assign rsp_valid_d = any_gnt;
  assign rsp_idx_d   = gnt_idx;
  assign rsp_err_d   = any_gnt & ~legal;
  assign rsp_we_d    = sel_req.we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  // Only successful reads carry RAM data; everything else reads back as zero.
  always_comb begin
    rsp.rdata = (rsp_valid_q && !rsp_we_q && !rsp_err_q) ? ram_rdata_i : 32'h0;
    rsp.err   = rsp_valid_q & rsp_err_q;
  end

  assign rvalid_o = rsp_valid_q ? (NUM_REQ'(1) << rsp_idx_q) : '0;
  assign rdata_o  = rsp.rdata;
  assign err_o    = rsp.err;

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rvalid_o));
  a_gnt_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 (|gnt_o) |=> (rvalid_o == $past(gnt_o)));
  a_en_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni) ram_en_o |-> (|gnt_o));

endmodule

// File: tb/tb_dp_ram_b_arbiter.sv
// tb/tb_dp_ram_b_arbiter.sv - directed self-checking bench for dp_ram_b_arbiter
module tb_dp_ram_b_arbiter;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req;
  logic [1:0][31:0] addr;
  logic [1:0]       we;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] wdata;
  logic [1:0]       gnt;
  logic [1:0]       rvalid;
  logic [31:0]      rdata;
  logic             err;
  logic             ram_en;
  logic [21:0]      ram_addr;
  logic             ram_we;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;

  logic [31:0] mem [0:1023];
  int n_checks;
  int n_fail;

  dp_ram_b_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(22)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .err_o       (err),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the RAM port B: byte-enabled write, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[11:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    we    = '0;
    be    = '0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    ram_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    mem[32'h104 >> 2] = 32'h01234567;
    mem[32'h200 >> 2] = 32'hAABBCCDD;

    rst_n = 1'b0;
    req   = '0;
    we    = '0;
    be    = '0;
    addr  = '0;
    wdata = '0;
    #3;
    check("rst_gnt",    32'(gnt), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata",  rdata, 32'h0);
    check("rst_err",    32'(err), 32'h0);
    check("rst_ram_en", 32'(ram_en), 32'h0);

    // 1: single read from M0
    do_reset();
    req = 2'b01; addr[0] = 32'h100; we = 2'b00; be[0] = 4'hF;
    #1;
    check("t1_gnt",      32'(gnt), 32'h1);
    check("t1_ram_en",   32'(ram_en), 32'h1);
    check("t1_ram_addr", 32'(ram_addr), 32'h100);
    tick();
    req = 2'b00;
    #1;
    check("t1_rvalid", 32'(rvalid), 32'h1);
    check("t1_rdata",  rdata, 32'hDEADBEEF);
    check("t1_err",    32'(err), 32'h0);

    // 2: continuous contention alternates grants
    do_reset();
    req = 2'b11; addr[0] = 32'h100; addr[1] = 32'h104;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t2_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i > 0) begin
        check("t2_rvalid", 32'(rvalid), (i % 2 == 0) ? 32'h2 : 32'h1);
        check("t2_rdata", rdata, (i % 2 == 0) ? 32'h01234567 : 32'hDEADBEEF);
      end
      tick();
    end
    req = 2'b00;
    #1;
    check("t2_last_rvalid", 32'(rvalid), 32'h2);
    check("t2_last_rdata",  rdata, 32'h01234567);

    // 3: partial write by M1 then read-back by M0
    do_reset();
    req = 2'b10; addr[1] = 32'h200; we = 2'b10; be[1] = 4'b0101; wdata[1] = 32'h11223344;
    #1;
    check("t3_wr_gnt", 32'(gnt), 32'h2);
    check("t3_wr_be",  32'(ram_be), 32'h5);
    check("t3_wr_we",  32'(ram_we), 32'h1);
    tick();
    req = 2'b01; we = 2'b00; addr[0] = 32'h200;
    #1;
    check("t3_wr_rvalid", 32'(rvalid), 32'h2);
    check("t3_wr_rdata",  rdata, 32'h0);
    check("t3_rd_gnt",    32'(gnt), 32'h1);
    tick();
    req = 2'b00;
    #1;
    check("t3_rd_rvalid", 32'(rvalid), 32'h1);
    check("t3_rd_rdata",  rdata, 32'hAA22CC44);

    // 4: out-of-range and boundary addresses
    do_reset();
    req = 2'b01; addr[0] = 32'hFFFF_FFF0;
    #1;
    check("t4_gnt",    32'(gnt), 32'h1);
    check("t4_ram_en", 32'(ram_en), 32'h0);
    tick();
    addr[0] = 32'h003F_FFFC;
    #1;
    check("t4_err_rvalid", 32'(rvalid), 32'h1);
    check("t4_err",        32'(err), 32'h1);
    check("t4_err_rdata",  rdata, 32'h0);
    check("t4_top_en",     32'(ram_en), 32'h1);
    check("t4_top_addr",   32'(ram_addr), 32'h3FFFFC);
    tick();
    addr[0] = 32'h0040_0000;
    #1;
    check("t4_top_err",  32'(err), 32'h0);
    check("t4_over_en",  32'(ram_en), 32'h0);
    tick();
    req = 2'b00;
    #1;
    check("t4_over_rvalid", 32'(rvalid), 32'h1);
    check("t4_over_err",    32'(err), 32'h1);

    // 5: reset right after a grant drops the response
    do_reset();
    req = 2'b01; addr[0] = 32'h100;
    #1;
    check("t5_gnt", 32'(gnt), 32'h1);
    #1;
    rst_n = 1'b0;
    req   = 2'b00;
    tick();
    check("t5_rvalid", 32'(rvalid), 32'h0);
    check("t5_rdata",  rdata, 32'h0);
    check("t5_err",    32'(err), 32'h0);
    check("t5_ram_en", 32'(ram_en), 32'h0);
    check("t5_gnt_rst", 32'(gnt), 32'h0);
    rst_n = 1'b1;
    req   = 2'b11; addr[1] = 32'h104;
    #1;
    check("t5_post_gnt", 32'(gnt), 32'h1);
    tick();

    // 6: M1 alone, then contention goes to M0 first
    do_reset();
    req = 2'b10; addr[1] = 32'h104; addr[0] = 32'h100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_solo_gnt", 32'(gnt), 32'h2);
      tick();
    end
    req = 2'b11;
    #1;
    check("t6_gnt_m0", 32'(gnt), 32'h1);
    tick();
    check("t6_gnt_m1",  32'(gnt), 32'h2);
    check("t6_rvalid",  32'(rvalid), 32'h1);
    tick();
    req = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
